// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central hazard / forwarding / multi-cycle control unit for
// the 5-stage core. It sits beside ID. It picks forwarding sources for the
// two ID read channels, detects load-use and RAW hazards, sequences
// multi-cycle EX operations (DIV, MADD) and drives the stall vector and the
// ID/EX bubble.
//
// Optional feature macro: PIPE_FWD_EN
//   defined   : EX/MEM forwarding is enabled. Only load-use hazards stall.
//   undefined : fwd_sel_* are tied to 00. Any EX or MEM RAW match stalls.
module pipeline_ctrl #(
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned MADD_CYCLES = 2,
    parameter int unsigned CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_reg_read_en_1,
    input  logic [4:0] id_reg_read_addr_1,
    input  logic       id_reg_read_en_2,
    input  logic [4:0] id_reg_read_addr_2,
    input  logic       ex_reg_write_en,
    input  logic [4:0] ex_reg_write_addr,
    input  logic       ex_is_load,
    input  logic       mem_reg_write_en,
    input  logic [4:0] mem_reg_write_addr,
    input  logic       ex_start_div,
    input  logic       ex_start_madd,
    output logic [1:0] fwd_sel_1,
    output logic [1:0] fwd_sel_2,
    output logic [5:0] stall,
    output logic       id_bubble,
    output logic       ex_busy,
    output logic       ex_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter reload values: the start cycle is the first occupancy cycle,
    // so BUSY counts the remaining N-1 cycles down to 1.
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MADD_LOAD = CNT_W'(MADD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] SRC_RF  = 2'b00;
    localparam logic [1:0] SRC_EX  = 2'b01;
    localparam logic [1:0] SRC_MEM = 2'b10;

    localparam logic [5:0] STALL_MULTI = 6'b001111;
    localparam logic [5:0] STALL_HAZ   = 6'b000111;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    logic             start_any;
    logic             ch1_act;
    logic             ch2_act;
    logic             ch1_ex;
    logic             ch1_mem;
    logic             ch2_ex;
    logic             ch2_mem;
    logic             hazard;
    logic [1:0]       fwd_raw_1;
    logic [1:0]       fwd_raw_2;

    assign start_any = ex_start_div | ex_start_madd;

    // Per-channel RAW match detection against the EX and MEM destinations
    always_comb begin
        ch1_act = id_reg_read_en_1 && (id_reg_read_addr_1 != '0);
        ch2_act = id_reg_read_en_2 && (id_reg_read_addr_2 != '0);
        ch1_ex  = ch1_act && ex_reg_write_en  && (id_reg_read_addr_1 == ex_reg_write_addr);
        ch1_mem = ch1_act && mem_reg_write_en && (id_reg_read_addr_1 == mem_reg_write_addr);
        ch2_ex  = ch2_act && ex_reg_write_en  && (id_reg_read_addr_2 == ex_reg_write_addr);
        ch2_mem = ch2_act && mem_reg_write_en && (id_reg_read_addr_2 == mem_reg_write_addr);
    end

`ifdef PIPE_FWD_EN
    // Forwarding source selection (EX beats MEM) and load-use detection
    always_comb begin
        fwd_raw_1 = SRC_RF;
        fwd_raw_2 = SRC_RF;
        if (ch1_ex) begin
            fwd_raw_1 = SRC_EX;
        end else if (ch1_mem) begin
            fwd_raw_1 = SRC_MEM;
        end
        if (ch2_ex) begin
            fwd_raw_2 = SRC_EX;
        end else if (ch2_mem) begin
            fwd_raw_2 = SRC_MEM;
        end
        hazard = ex_is_load && (ch1_ex || ch2_ex);
    end
`else
    // No forwarding path: every RAW dependency on EX or MEM must stall.
    // The load term is already implied by the EX match, it is kept so the
    // load flag has the same meaning in both builds.
    always_comb begin
        fwd_raw_1 = SRC_RF;
        fwd_raw_2 = SRC_RF;
        hazard    = ch1_ex || ch1_mem || ch2_ex || ch2_mem
                    || (ex_is_load && (ch1_ex || ch2_ex));
    end
`endif

    // State and counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Next-state and counter update for the multi-cycle sequencer
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (start_any) begin
                    state_nxt = BUSY;
                    count_nxt = ex_start_div ? DIV_LOAD : MADD_LOAD;
                end
            end
            BUSY: begin
                if (count == CNT_ONE) begin
                    state_nxt = DONE;
                    count_nxt = '0;
                end else begin
                    count_nxt = count - CNT_ONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // Output decode: multi-cycle stall overrides hazard stall; reset zeroes all
    always_comb begin
        logic multi;
        multi     = 1'b0;
        fwd_sel_1 = '0;
        fwd_sel_2 = '0;
        stall     = '0;
        id_bubble = 1'b0;
        ex_busy   = 1'b0;
        ex_done   = 1'b0;
        if (!rst) begin
            fwd_sel_1 = fwd_raw_1;
            fwd_sel_2 = fwd_raw_2;
            case (state)
                IDLE:    multi = start_any;
                BUSY:    multi = 1'b1;
                DONE:    ex_done = 1'b1;
                default: multi = 1'b0;
            endcase
            if (multi) begin
                stall   = STALL_MULTI;
                ex_busy = 1'b1;
            end else if (hazard) begin
                stall     = STALL_HAZ;
                id_bubble = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a behavioural model that tracks "cycle when the result is due".
module tb_pipeline_ctrl;

    localparam int DIV_N  = 32;
    localparam int MADD_N = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_reg_read_en_1;
    logic [4:0] id_reg_read_addr_1;
    logic       id_reg_read_en_2;
    logic [4:0] id_reg_read_addr_2;
    logic       ex_reg_write_en;
    logic [4:0] ex_reg_write_addr;
    logic       ex_is_load;
    logic       mem_reg_write_en;
    logic [4:0] mem_reg_write_addr;
    logic       ex_start_div;
    logic       ex_start_madd;
    logic [1:0] fwd_sel_1;
    logic [1:0] fwd_sel_2;
    logic [5:0] stall;
    logic       id_bubble;
    logic       ex_busy;
    logic       ex_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_at = -1;   // absolute cycle in which ex_done is due, -1 when idle

    pipeline_ctrl #(
        .DIV_CYCLES (DIV_N),
        .MADD_CYCLES(MADD_N),
        .CNT_W      (6)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .id_reg_read_en_1  (id_reg_read_en_1),
        .id_reg_read_addr_1(id_reg_read_addr_1),
        .id_reg_read_en_2  (id_reg_read_en_2),
        .id_reg_read_addr_2(id_reg_read_addr_2),
        .ex_reg_write_en   (ex_reg_write_en),
        .ex_reg_write_addr (ex_reg_write_addr),
        .ex_is_load        (ex_is_load),
        .mem_reg_write_en  (mem_reg_write_en),
        .mem_reg_write_addr(mem_reg_write_addr),
        .ex_start_div      (ex_start_div),
        .ex_start_madd     (ex_start_madd),
        .fwd_sel_1         (fwd_sel_1),
        .fwd_sel_2         (fwd_sel_2),
        .stall             (stall),
        .id_bubble         (id_bubble),
        .ex_busy           (ex_busy),
        .ex_done           (ex_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    function automatic logic raw(input logic en, input logic [4:0] a,
                                 input logic we, input logic [4:0] wa);
        return en && (a != 5'd0) && we && (a == wa);
    endfunction

    // Model state advance: a sequence started in cycle c yields ex_done in c+N
    always @(posedge clk) begin
        if (rst) begin
            done_at = -1;
        end else if (done_at == cyc) begin
            done_at = -1;
        end else if (done_at < 0 && (ex_start_div || ex_start_madd)) begin
            done_at = cyc + (ex_start_div ? DIV_N : MADD_N);
        end
        cyc++;
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [1:0] e_f1, e_f2;
        logic [5:0] e_st;
        logic       e_bub, e_busy, e_done, haz;
        logic       x1, m1, x2, m2;
        e_f1 = 2'd0; e_f2 = 2'd0; e_st = 6'd0;
        e_bub = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (!rst) begin
            x1 = raw(id_reg_read_en_1, id_reg_read_addr_1, ex_reg_write_en, ex_reg_write_addr);
            m1 = raw(id_reg_read_en_1, id_reg_read_addr_1, mem_reg_write_en, mem_reg_write_addr);
            x2 = raw(id_reg_read_en_2, id_reg_read_addr_2, ex_reg_write_en, ex_reg_write_addr);
            m2 = raw(id_reg_read_en_2, id_reg_read_addr_2, mem_reg_write_en, mem_reg_write_addr);
`ifdef PIPE_FWD_EN
            e_f1 = x1 ? 2'd1 : (m1 ? 2'd2 : 2'd0);
            e_f2 = x2 ? 2'd1 : (m2 ? 2'd2 : 2'd0);
            haz  = ex_is_load && (x1 || x2);
`else
            haz  = x1 || m1 || x2 || m2;
`endif
            if (done_at == cyc)       e_done = 1'b1;
            else if (done_at > cyc)   e_busy = 1'b1;
            else if (ex_start_div || ex_start_madd) e_busy = 1'b1;
            if (e_busy) begin
                e_st = 6'b001111;
            end else if (haz) begin
                e_st = 6'b000111;
                e_bub = 1'b1;
            end
        end
        chk("fwd_sel_1", 8'(fwd_sel_1), 8'(e_f1));
        chk("fwd_sel_2", 8'(fwd_sel_2), 8'(e_f2));
        chk("stall", 8'(stall), 8'(e_st));
        chk("id_bubble", 8'(id_bubble), 8'(e_bub));
        chk("ex_busy", 8'(ex_busy), 8'(e_busy));
        chk("ex_done", 8'(ex_done), 8'(e_done));
    end

    task automatic clear_inputs();
        id_reg_read_en_1 = 0; id_reg_read_addr_1 = 0;
        id_reg_read_en_2 = 0; id_reg_read_addr_2 = 0;
        ex_reg_write_en = 0;  ex_reg_write_addr = 0; ex_is_load = 0;
        mem_reg_write_en = 0; mem_reg_write_addr = 0;
        ex_start_div = 0;     ex_start_madd = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        // Reset: all outputs zero
        @(negedge clk);
        chk("rst_stall", 8'(stall), 8'd0);
        chk("rst_busy", 8'(ex_busy), 8'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Forwarding: EX and MEM both write r5, channel 1 reads r5
        id_reg_read_en_1 = 1; id_reg_read_addr_1 = 5;
        ex_reg_write_en = 1;  ex_reg_write_addr = 5;
        mem_reg_write_en = 1; mem_reg_write_addr = 5;
        @(negedge clk);
`ifdef PIPE_FWD_EN
        chk("fwd_ex_prio", 8'(fwd_sel_1), 8'd1);
        chk("fwd_ex_nostall", 8'(stall), 8'd0);
`else
        chk("nofwd_sel", 8'(fwd_sel_1), 8'd0);
        chk("nofwd_stall", 8'(stall), 8'b000111);
        chk("nofwd_bubble", 8'(id_bubble), 8'd1);
`endif
        next_cycle();
        ex_reg_write_en = 0;
        @(negedge clk);
`ifdef PIPE_FWD_EN
        chk("fwd_mem", 8'(fwd_sel_1), 8'd2);
`else
        chk("nofwd_mem_stall", 8'(stall), 8'b000111);
`endif
        next_cycle();
        id_reg_read_addr_1 = 0;
        @(negedge clk);
        chk("fwd_r0", 8'(fwd_sel_1), 8'd0);
        chk("r0_nostall", 8'(stall), 8'd0);
        next_cycle();

        // Load-use on channel 2 reading r7, then the load clears
        clear_inputs();
        id_reg_read_en_2 = 1; id_reg_read_addr_2 = 7;
        ex_reg_write_en = 1;  ex_reg_write_addr = 7; ex_is_load = 1;
        @(negedge clk);
        chk("lu_stall", 8'(stall), 8'b000111);
        chk("lu_bubble", 8'(id_bubble), 8'd1);
        next_cycle();
        ex_is_load = 0;
        @(negedge clk);
`ifdef PIPE_FWD_EN
        chk("after_lu_stall", 8'(stall), 8'd0);
        chk("after_lu_fwd2", 8'(fwd_sel_2), 8'd1);
`else
        chk("after_lu_stall", 8'(stall), 8'b000111);
        chk("after_lu_fwd2", 8'(fwd_sel_2), 8'd0);
`endif
        next_cycle();

        // DIV held from cycle 0, then both starts together (div wins)
        for (int pass = 0; pass < 2; pass++) begin
            clear_inputs();
            ex_start_div = 1;
            ex_start_madd = (pass == 1);
            for (int k = 0; k <= DIV_N; k++) begin
                @(negedge clk);
                chk("div_stall", 8'(stall), (k < DIV_N) ? 8'b001111 : 8'd0);
                chk("div_done", 8'(ex_done), (k == DIV_N) ? 8'd1 : 8'd0);
                next_cycle();
            end
            clear_inputs();
            @(negedge clk);
            chk("div_idle_busy", 8'(ex_busy), 8'd0);
            chk("div_idle_done", 8'(ex_done), 8'd0);
            next_cycle();
        end

        // MADD alone with a load-use present throughout
        clear_inputs();
        ex_start_madd = 1;
        id_reg_read_en_1 = 1; id_reg_read_addr_1 = 9;
        ex_reg_write_en = 1;  ex_reg_write_addr = 9; ex_is_load = 1;
        for (int k = 0; k <= MADD_N; k++) begin
            @(negedge clk);
            chk("madd_stall", 8'(stall), (k < MADD_N) ? 8'b001111 : 8'b000111);
            chk("madd_bubble", 8'(id_bubble), (k < MADD_N) ? 8'd0 : 8'd1);
            chk("madd_done", 8'(ex_done), (k == MADD_N) ? 8'd1 : 8'd0);
            next_cycle();
        end
        clear_inputs();
        next_cycle();

        // Reset mid-divide at cycle 10
        ex_start_div = 1;
        for (int k = 0; k <= 40; k++) begin
            if (k == 10) rst = 1;
            if (k == 11) begin rst = 0; ex_start_div = 0; end
            @(negedge clk);
            if (k == 10) begin
                chk("midrst_stall", 8'(stall), 8'd0);
                chk("midrst_busy", 8'(ex_busy), 8'd0);
            end
            if (k >= 11) chk("midrst_nodone", 8'(ex_done), 8'd0);
            next_cycle();
        end

        // Randomized traffic, small address space to provoke matches
        for (int i = 0; i < 3000; i++) begin
            rst                = ($urandom_range(0, 149) == 0);
            id_reg_read_en_1   = $urandom_range(0, 1);
            id_reg_read_addr_1 = 5'($urandom_range(0, 3));
            id_reg_read_en_2   = $urandom_range(0, 1);
            id_reg_read_addr_2 = 5'($urandom_range(0, 3));
            ex_reg_write_en    = $urandom_range(0, 1);
            ex_reg_write_addr  = 5'($urandom_range(0, 3));
            ex_is_load         = $urandom_range(0, 1);
            mem_reg_write_en   = $urandom_range(0, 1);
            mem_reg_write_addr = 5'($urandom_range(0, 3));
            ex_start_div       = ($urandom_range(0, 15) == 0);
            ex_start_madd      = ($urandom_range(0, 7) == 0);
            next_cycle();
        end
        rst = 0;
        clear_inputs();
        next_cycle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central pipeline control unit for the 5-stage core; sits beside the ID stage and consumes its register-read requests plus the EX and MEM write-back info.
- Selects the operand forwarding source for each ID read channel.
- Detects load-use hazards.
- Sequences multi-cycle EX operations (DIV, MADD) with a counter FSM.
- Drives the per-stage stall vector and the ID/EX bubble.

Parameters:
DIV_CYCLES, 32, total EX occupancy cycles of a divide before its result is valid (must be >= 2)
MADD_CYCLES, 2, total EX occupancy cycles of a multiply-accumulate (must be >= 2)
CNT_W, 6, counter width; must hold max(DIV_CYCLES, MADD_CYCLES)-1

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
id_reg_read_en_1  in  1  ID read channel 1 enable
id_reg_read_addr_1  in  5  ID read channel 1 address
id_reg_read_en_2  in  1  ID read channel 2 enable
id_reg_read_addr_2  in  5  ID read channel 2 address
ex_reg_write_en  in  1  instruction in EX writes a GPR
ex_reg_write_addr  in  5  EX destination register
ex_is_load  in  1  instruction in EX is a load
mem_reg_write_en  in  1  instruction in MEM writes a GPR
mem_reg_write_addr  in  5  MEM destination register
ex_start_div  in  1  divide present in EX (level, held while in EX)
ex_start_madd  in  1  MADD/MSUB present in EX (level)
fwd_sel_1  out  2  channel 1 source: 00 regfile, 01 EX result, 10 MEM result
fwd_sel_2  out  2  channel 2 source, same encoding
stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0)
id_bubble  out  1  load NOP into ID/EX this cycle
ex_busy  out  1  multi-cycle op in progress
ex_done  out  1  multi-cycle result valid this cycle (1-cycle pulse)

Behaviour:
Reset
- rst high at a clock edge: state becomes IDLE and count becomes 0.
- All outputs are forced 0 combinationally while rst = 1.
- Reset mid-operation aborts the sequence. No ex_done is produced.

Forwarding (combinational)
- Applies per channel, only when read_en = 1 and addr != 0.
- EX match (ex_reg_write_en and addr equal) -> 01. Else MEM match -> 10. Else 00.
- EX has priority over MEM.
- A disabled channel or addr 0 -> 00.

Load-use (combinational)
- Triggers when ex_is_load and ex_reg_write_en, and any enabled channel with nonzero addr matches ex_reg_write_addr.
- Response: stall = 000111, id_bubble = 1.
- fwd_sel is still driven for that channel but is don't-care.

Multi-cycle FSM
States: IDLE, BUSY, DONE. Counter count[CNT_W-1:0]. N = DIV_CYCLES if ex_start_div, else MADD_CYCLES; div wins if both starts are asserted.
- IDLE:
  - If either start is asserted: stall = 001111, ex_busy = 1. Next state BUSY, count <= N-1.
  - Otherwise stay in IDLE.
- BUSY:
  - stall = 001111, ex_busy = 1.
  - If count == 1: next state DONE. Else count <= count-1.
- DONE:
  - ex_done = 1, ex_busy = 0, stall = 000000. Starts are ignored. Next state IDLE.
- Timing: ex_done is asserted exactly N cycles after the first start cycle. The op then advances to MEM on the DONE edge.
- Back-to-back: a new start seen in IDLE the cycle after DONE begins a new sequence.

Priority
- Multi-cycle stall (001111) overrides load-use.
- When overridden, id_bubble = 0.
- With no hazard: stall = 000000, id_bubble = 0.

Optional Feature:
PIPE_FWD_EN
- Defined: forwarding as above.
- Undefined:
  - fwd_sel_1 and fwd_sel_2 are tied to 00.
  - Any EX or MEM RAW match (nonzero addr, enabled channel, write_en) causes stall = 000111 and id_bubble = 1, with the same priority rules.
  - The FSM is unchanged.

Test Plan:
- Forwarding: rd1 en, addr 5; EX writes r5; MEM writes r5 -> fwd_sel_1 = 01. Drop EX write_en -> 10. Set addr 0 -> 00.
- Load-use: ex_is_load = 1, EX writes r7, ID reads r7 on ch2 -> stall = 000111, id_bubble = 1. Clear the load next cycle -> stall = 0, fwd_sel_2 = 01.
- DIV: ex_start_div held from cycle 0 -> stall = 001111 in cycles 0..31, ex_done = 1 only in cycle 32, stall = 0 in cycle 32, IDLE in cycle 33.
- MADD plus priority: both starts asserted at cycle 0 -> div sequence is taken (done at 32). Separately, madd alone -> stall in cycles 0..1, done in cycle 2. A load-use during BUSY -> stall = 001111, id_bubble = 0.
- Reset mid-op: start div, assert rst at cycle 10 for 1 cycle -> all outputs 0 while rst is high; FSM in IDLE at cycle 11; no ex_done in cycles 11..40 if starts stay low.
- PIPE_FWD_EN undefined: EX writes r3, ID reads r3 (non-load) -> fwd_sel_1 = 00, stall = 000111, id_bubble = 1.
